// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer for the encoder -> channel -> decoder loopback.
// Pulls FRAME_LEN source bits into the encoder, flushes TAIL zero bits, forwards
// encoder symbols to the decoder and scores decoded bits against a delayed copy
// of the sent data bits.
// Optional feature: define VITERBI_ERR_INJ_EN to enable periodic channel error
// injection (bit 0 of the symbol flipped on 2 of every 2^ERR_N data symbols).
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL      = 2,
    parameter int DEC_LAT   = 24,
    parameter int ERR_N     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        src_bit_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic        enc_en_o,
    output logic        enc_bit_o,
    input  logic        enc_valid_i,
    input  logic [1:0]  enc_sym_i,
    output logic        dec_en_o,
    output logic [1:0]  dec_sym_o,
    input  logic        dec_bit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] err_inj_ct_o,
    output logic [15:0] bit_err_ct_o
);

    localparam int TW = (TAIL > 1) ? $clog2(TAIL + 1) : 1;
    localparam int DW = $clog2(DEC_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TAIL, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [15:0]     bit_ct;
    logic [TW-1:0]   tail_ct;
    logic [DW-1:0]   drain_ct;
    logic            enc_data;     // the bit currently on enc_bit_o is a data bit
    logic            handshake;
    logic            start_acc;
    logic [1:0]      mask;
    logic            dly_vld [DEC_LAT];
    logic            dly_bit [DEC_LAT];

    assign src_ready_o = (state == S_LOAD);
    assign busy_o      = (state != S_IDLE);
    assign handshake   = src_valid_i & src_ready_o;
    assign start_acc   = start_i & (state == S_IDLE);

    // Frame sequencing FSM with registered encoder drive and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            bit_ct    <= '0;
            tail_ct   <= '0;
            drain_ct  <= '0;
            enc_en_o  <= 1'b0;
            enc_bit_o <= 1'b0;
            enc_data  <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            enc_en_o  <= 1'b0;
            enc_bit_o <= 1'b0;
            enc_data  <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state  <= S_LOAD;
                        bit_ct <= '0;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        enc_en_o  <= 1'b1;
                        enc_bit_o <= src_bit_i;
                        enc_data  <= 1'b1;
                        bit_ct    <= bit_ct + 16'd1;
                        // Leaving on the last handshake drops ready on the same edge.
                        if (bit_ct == 16'(FRAME_LEN - 1)) begin
                            state   <= S_TAIL;
                            tail_ct <= '0;
                        end
                    end
                end
                S_TAIL: begin
                    enc_en_o <= 1'b1;
                    tail_ct  <= tail_ct + 1'b1;
                    if (tail_ct == TW'(TAIL - 1)) begin
                        state    <= S_DRAIN;
                        drain_ct <= '0;
                    end
                end
                S_DRAIN: begin
                    // DEC_LAT+2 cycles guarantees the last data bit has left the delay line.
                    if (drain_ct == DW'(DEC_LAT + 1)) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end else begin
                        drain_ct <= drain_ct + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Scoring delay line: stage 0 captures the encoder beat, last stage meets dec_bit_i.
    for (genvar gi = 0; gi < DEC_LAT; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            // Load the head stage; tail bits enter with vld cleared.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly_vld[gi] <= 1'b0;
                    dly_bit[gi] <= 1'b0;
                end else begin
                    dly_vld[gi] <= enc_en_o & enc_data;
                    dly_bit[gi] <= enc_bit_o;
                end
            end
        end else begin : g_body
            // Shift one stage per cycle regardless of source stalls.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly_vld[gi] <= 1'b0;
                    dly_bit[gi] <= 1'b0;
                end else begin
                    dly_vld[gi] <= dly_vld[gi-1];
                    dly_bit[gi] <= dly_bit[gi-1];
                end
            end
        end
    end

    // Saturating decoded-bit mismatch counter, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_err_ct_o <= '0;
        end else if (start_acc) begin
            bit_err_ct_o <= '0;
        end else if (dly_vld[DEC_LAT-1] && (dly_bit[DEC_LAT-1] != dec_bit_i) &&
                     (bit_err_ct_o != 16'hFFFF)) begin
            bit_err_ct_o <= bit_err_ct_o + 16'd1;
        end
    end

`ifdef VITERBI_ERR_INJ_EN
    logic [16:0] sym_ct;

    // Corrupt symbol bit 0 on the last two symbols of each 2^ERR_N block of data symbols.
    always_comb begin
        mask = 2'b00;
        if (enc_valid_i && busy_o && (sym_ct < 17'(FRAME_LEN)) && (&sym_ct[ERR_N-1:1]))
            mask = 2'b01;
    end

    // Count frame symbols and injected errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_ct       <= '0;
            err_inj_ct_o <= '0;
        end else if (start_acc) begin
            sym_ct       <= '0;
            err_inj_ct_o <= '0;
        end else if (enc_valid_i && busy_o) begin
            sym_ct <= sym_ct + 17'd1;
            if (mask != 2'b00)
                err_inj_ct_o <= err_inj_ct_o + 16'd1;
        end
    end
`else
    assign mask         = 2'b00;
    assign err_inj_ct_o = '0;
`endif

    // Channel: one-cycle forward of encoder symbols to the decoder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_en_o  <= 1'b0;
            dec_sym_o <= 2'b00;
        end else begin
            dec_en_o  <= enc_valid_i;
            dec_sym_o <= enc_sym_i ^ mask;
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: encoder and decoder stubs around the DUT,
// per-frame expectations queued at stimulus time and consumed by a monitor.
module tb_viterbi_frame_ctrl;

    localparam int FRAME_LEN = 256;
    localparam int TAIL      = 2;
    localparam int DEC_LAT   = 24;
    localparam int ERR_N     = 4;
`ifdef VITERBI_ERR_INJ_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        src_bit_i = 1'b0;
    logic        src_valid_i = 1'b0;
    logic        src_ready_o;
    logic        enc_en_o;
    logic        enc_bit_o;
    logic        enc_valid_i = 1'b0;
    logic [1:0]  enc_sym_i = 2'b00;
    logic        dec_en_o;
    logic [1:0]  dec_sym_o;
    logic        dec_bit_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] err_inj_ct_o;
    logic [15:0] bit_err_ct_o;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int enc_cnt = 0;
    int inv_mode = 0;
    bit track = 1'b0;

    int exp_bits[$];
    int exp_sym[$];
    int exp_inj[$];
    int exp_berr[$];

    viterbi_frame_ctrl #(
        .FRAME_LEN(FRAME_LEN), .TAIL(TAIL), .DEC_LAT(DEC_LAT), .ERR_N(ERR_N)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .src_bit_i(src_bit_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
        .enc_en_o(enc_en_o), .enc_bit_o(enc_bit_o),
        .enc_valid_i(enc_valid_i), .enc_sym_i(enc_sym_i),
        .dec_en_o(dec_en_o), .dec_sym_o(dec_sym_o), .dec_bit_i(dec_bit_i),
        .busy_o(busy_o), .done_o(done_o),
        .err_inj_ct_o(err_inj_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Encoder stub: K=3 code, symbol one cycle after enable, state cleared when idle.
    logic [1:0] enc_sr = 2'b00;
    always @(posedge clk) begin
        if (enc_en_o) begin
            enc_valid_i <= 1'b1;
            enc_sym_i   <= {enc_bit_o ^ enc_sr[0] ^ enc_sr[1], enc_bit_o ^ enc_sr[1]};
            enc_sr      <= {enc_sr[0], enc_bit_o};
        end else begin
            enc_valid_i <= 1'b0;
            if (!busy_o) enc_sr <= 2'b00;
        end
    end

    // Decoder stub: returns each encoder-enabled bit DEC_LAT cycles later, optionally inverted.
    function automatic logic inv_hit(input int idx);
        return ((inv_mode == 1) && (idx == 10)) || ((inv_mode == 2) && (idx < FRAME_LEN));
    endfunction

    logic pipe [DEC_LAT];
    int   didx = 0;
    always @(posedge clk) begin
        if (!busy_o) didx <= 0;
        else if (enc_en_o) didx <= didx + 1;
        pipe[0] <= enc_en_o ? (enc_bit_o ^ inv_hit(didx)) : 1'($urandom_range(0, 1));
        for (int i = 1; i < DEC_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dec_bit_i = pipe[DEC_LAT-1];

    // Monitor: consume expectations whenever the DUT presents an output beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!busy_o) enc_cnt = 0;
            if (rst && track) begin
                if (enc_en_o) begin
                    enc_cnt++;
                    if (exp_bits.size() == 0) chk("enc_bit_extra", 1, 0);
                    else chk("enc_bit", int'(enc_bit_o), exp_bits.pop_front());
                end
                if (dec_en_o) begin
                    if (exp_sym.size() == 0) chk("dec_sym_extra", 1, 0);
                    else chk("dec_sym", int'(dec_sym_o), exp_sym.pop_front());
                end
                if (done_o) begin
                    done_seen++;
                    chk("enc_count", enc_cnt, FRAME_LEN + TAIL);
                    chk("bits_left", exp_bits.size(), 0);
                    chk("syms_left", exp_sym.size(), 0);
                    if (exp_inj.size() == 0) chk("done_extra", 1, 0);
                    else begin
                        chk("err_inj_ct", int'(err_inj_ct_o), exp_inj.pop_front());
                        chk("bit_err_ct", int'(bit_err_ct_o), exp_berr.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_frame(input bit vrand, input int imode, input bit extra_start,
                             input bit abort, input string tag);
        logic bits [FRAME_LEN];
        int   seq [FRAME_LEN + TAIL];
        int   idx = 0;
        int   cyc = 0;
        int   ninj = 0;
        int   eberr;
        int   d0;
        int   b1, b2, s;
        bit   inj, hs;
        bit   pulsed = 1'b0;

        for (int k = 0; k < FRAME_LEN; k++) bits[k] = 1'($urandom_range(0, 1));
        inv_mode = imode;
        eberr = (imode == 0) ? 0 : ((imode == 1) ? 1 : FRAME_LEN);
        if (!abort) begin
            for (int k = 0; k < FRAME_LEN + TAIL; k++) begin
                seq[k] = (k < FRAME_LEN) ? int'(bits[k]) : 0;
                b1 = (k >= 1) ? seq[k-1] : 0;
                b2 = (k >= 2) ? seq[k-2] : 0;
                s  = 2 * (seq[k] ^ b1 ^ b2) + (seq[k] ^ b2);
                inj = ERR_ON && (k < FRAME_LEN) && ((k % (1 << ERR_N)) >= (1 << ERR_N) - 2);
                if (inj) begin
                    s = s ^ 1;
                    ninj++;
                end
                exp_bits.push_back(seq[k]);
                exp_sym.push_back(s);
            end
            exp_inj.push_back(ninj);
            exp_berr.push_back(eberr);
        end
        track = !abort;
        d0 = done_seen;

        @(posedge clk); #1;
        start_i = 1'b1;
        while (idx < FRAME_LEN && cyc < 8 * FRAME_LEN) begin
            src_valid_i = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
            src_bit_i   = bits[idx];
            @(negedge clk);
            hs = src_valid_i && src_ready_o;
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
            if (hs) idx++;
            if (extra_start && !pulsed && idx == 50) begin
                start_i = 1'b1;
                pulsed  = 1'b1;
            end
            if (abort && idx == 100) begin
                rst = 1'b0;
                src_valid_i = 1'b0;
                #1;
                chk("rst_busy", int'(busy_o), 0);
                chk("rst_ready", int'(src_ready_o), 0);
                chk("rst_enc_en", int'(enc_en_o), 0);
                chk("rst_dec_en", int'(dec_en_o), 0);
                chk("rst_done", int'(done_o), 0);
                chk("rst_bit_err", int'(bit_err_ct_o), 0);
                chk("rst_err_inj", int'(err_inj_ct_o), 0);
                @(posedge clk); #1;
                rst = 1'b1;
                repeat (DEC_LAT + 5) @(posedge clk);
                #1;
                chk("abort_no_done", done_seen, d0);
                chk("abort_idle", int'(busy_o), 0);
                $display("frame %s: aborted by reset at bit %0d", tag, idx);
                return;
            end
        end
        src_valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < FRAME_LEN) chk("feed_timeout", idx, FRAME_LEN);

        cyc = 0;
        while (cyc < FRAME_LEN + TAIL + DEC_LAT + 64) begin
            @(negedge clk);
            if (done_o) break;
            cyc++;
        end
        if (!done_o) chk("done_timeout", 0, 1);
        if (extra_start) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        repeat (40) @(posedge clk);
        #1;
        chk("post_idle", int'(busy_o), 0);
        chk("post_done_once", done_seen, d0 + 1);
        chk("hold_bit_err", int'(bit_err_ct_o), eberr);
        chk("hold_err_inj", int'(err_inj_ct_o), ninj);
        $display("frame %s: bit_err=%0d err_inj=%0d done_count=%0d",
                 tag, bit_err_ct_o, err_inj_ct_o, done_seen - d0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_ready", int'(src_ready_o), 0);
        chk("reset_enc_en", int'(enc_en_o), 0);
        chk("reset_dec_en", int'(dec_en_o), 0);
        chk("reset_dec_sym", int'(dec_sym_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_bit_err", int'(bit_err_ct_o), 0);
        chk("reset_err_inj", int'(err_inj_ct_o), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(1'b0, 0, 1'b0, 1'b0, "plain");
        run_frame(1'b1, 1, 1'b0, 1'b0, "toggle_inv10");
        run_frame(1'b0, 2, 1'b1, 1'b0, "inv_all_extra_start");
        run_frame(1'b0, 2, 1'b0, 1'b1, "abort");
        run_frame(1'b1, 0, 1'b0, 1'b0, "after_abort");

        chk("queues_empty", exp_bits.size() + exp_sym.size() + exp_inj.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
